// File: rtl/gpio_bank_if.sv
// gpio_bank_if: data-memory bus seen by gpio_bank (word write, registered read).
// The core drives WE/A/WD through the master modport; the bank returns RD.
interface gpio_bank_if;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output WE, output A, output WD, input RD);
    modport slave  (input WE, input A, input WD, output RD);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with set/clear aliases and a two-flop input sync.
// Define GPIO_BANK_IRQ_EN to build the IE/IS/EDGE edge-interrupt block and irq.
module gpio_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned N_PINS    = 8
) (
    input  logic              CLK,
    input  logic              reset,
    gpio_bank_if.slave        bus,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);

    typedef enum logic [2:0] {
        R_OUT  = 3'd0,
        R_DIR  = 3'd1,
        R_IN   = 3'd2,
        R_SET  = 3'd3,
        R_CLR  = 3'd4,
        R_IE   = 3'd5,
        R_IS   = 3'd6,
        R_EDGE = 3'd7
    } reg_off_t;

    reg_off_t          off;
    logic              sel;
    logic              wr;
    logic [N_PINS-1:0] wd;
    logic [N_PINS-1:0] out_r;
    logic [N_PINS-1:0] dir_r;
    logic [N_PINS-1:0] sync1;
    logic [N_PINS-1:0] sync2;
    logic [31:0]       rd_next;
    logic              unused_bits;

    assign sel = (bus.A[31:5] == BASE_ADDR[31:5]);
    assign off = reg_off_t'(bus.A[4:2]);
    assign wr  = bus.WE & sel;
    assign wd  = bus.WD[N_PINS-1:0];

    // Byte lane and data bits above N_PINS have no destination.
    assign unused_bits = ^{bus.A[1:0], bus.WD};

    assign gpio_out = out_r;
    assign gpio_oe  = dir_r;

`ifdef GPIO_BANK_IRQ_EN
    logic [N_PINS-1:0] ie_r;
    logic [N_PINS-1:0] is_r;
    logic [N_PINS-1:0] edge_r;
    logic [N_PINS-1:0] prev;
    logic [N_PINS-1:0] edge_hit;
    logic [N_PINS-1:0] w1c;

    // A change qualifies when the new level matches the selected polarity.
    assign edge_hit = (sync2 ^ prev) & ~(sync2 ^ edge_r);
    assign w1c      = (wr && off == R_IS) ? wd : '0;
    assign irq      = |(is_r & ie_r);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ie_r   <= '0;
            is_r   <= '0;
            edge_r <= '0;
            prev   <= '0;
        end else begin
            prev <= sync2;
            // A new edge overrides a clear of the same bit.
            is_r <= (is_r & ~w1c) | edge_hit;
            if (wr && off == R_IE)   ie_r   <= wd;
            if (wr && off == R_EDGE) edge_r <= wd;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        if (sel) begin
            case (off)
                R_OUT:   rd_next = 32'(out_r);
                R_DIR:   rd_next = 32'(dir_r);
                R_IN:    rd_next = 32'(sync2);
`ifdef GPIO_BANK_IRQ_EN
                R_IE:    rd_next = 32'(ie_r);
                R_IS:    rd_next = 32'(is_r);
                R_EDGE:  rd_next = 32'(edge_r);
`endif
                default: rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_r  <= '0;
            dir_r  <= '0;
            sync1  <= '0;
            sync2  <= '0;
            bus.RD <= '0;
        end else begin
            sync1  <= gpio_in;
            sync2  <= sync1;
            bus.RD <= rd_next;
            if (wr) begin
                case (off)
                    R_OUT:   out_r <= wd;
                    R_DIR:   dir_r <= wd;
                    R_SET:   out_r <= out_r | wd;
                    R_CLR:   out_r <= out_r & ~wd;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and randomized checks of gpio_bank against a behavioural model.
// Three instances (8, 1 and 32 pins) share the same bus stimulus.
module tb_gpio_bank;

    localparam logic [31:0] B    = 32'h8000_0000;
    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic CLK;
    logic reset;

    gpio_bank_if bus();
    gpio_bank_if bus1();
    gpio_bank_if bus32();

    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;
    logic [0:0]  in1;
    logic [0:0]  out1;
    logic [0:0]  oe1;
    logic        irq1;
    logic [31:0] in32;
    logic [31:0] out32;
    logic [31:0] oe32;
    logic        irq32;

    int checks = 0;
    int errors = 0;

    // Reference model state: register contents and the history of sampled pin values.
    logic [31:0] m_out, m_dir, m_ie, m_is, m_edge;
    logic [31:0] hist[$];

    gpio_bank #(.BASE_ADDR(B), .N_PINS(8)) dut (
        .CLK(CLK), .reset(reset), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_bank #(.BASE_ADDR(B), .N_PINS(1)) dut_n1 (
        .CLK(CLK), .reset(reset), .bus(bus1),
        .gpio_in(in1), .gpio_out(out1), .gpio_oe(oe1), .irq(irq1)
    );

    gpio_bank #(.BASE_ADDR(B), .N_PINS(32)) dut_n32 (
        .CLK(CLK), .reset(reset), .bus(bus32),
        .gpio_in(in32), .gpio_out(out32), .gpio_oe(oe32), .irq(irq32)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef GPIO_BANK_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_dir  = '0;
        m_ie   = '0;
        m_is   = '0;
        m_edge = '0;
        hist   = '{32'h0, 32'h0, 32'h0};
    endtask

    // hist[0]: value sampled at the latest edge, hist[1]: value visible in IN, hist[2]: one older.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned o;
        if (a[31:5] != B[31:5]) return 32'h0;
        o = int'(a[4:2]);
        case (o)
            0: return m_out;
            1: return m_dir;
            2: return hist[1] & MASK;
            5: return IRQ_BUILD ? m_ie : 32'h0;
            6: return IRQ_BUILD ? m_is : 32'h0;
            7: return IRQ_BUILD ? m_edge : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] events;
        logic [31:0] w;
        int unsigned o;
        events = '0;
        for (int i = 0; i < 8; i++) begin
            if (hist[1][i] != hist[2][i] && hist[1][i] == m_edge[i]) events[i] = 1'b1;
        end
        w = wd & MASK;
        o = int'(a[4:2]);
        if (we && a[31:5] == B[31:5]) begin
            case (o)
                0: m_out = w;
                1: m_dir = w;
                3: m_out = m_out | w;
                4: m_out = m_out & ~w;
                5: if (IRQ_BUILD) m_ie = w;
                6: if (IRQ_BUILD) m_is = m_is & ~w;
                7: if (IRQ_BUILD) m_edge = w;
                default: ;
            endcase
        end
        if (IRQ_BUILD) m_is = m_is | events;
        hist.push_front({24'h0, gpio_in});
        void'(hist.pop_back());
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        bus.WE   = we; bus.A   = a; bus.WD   = wd;
        bus1.WE  = we; bus1.A  = a; bus1.WD  = wd;
        bus32.WE = we; bus32.A = a; bus32.WD = wd;
        exp_rd = model_read(a);
        model_edge(we, a, wd);
        @(posedge CLK);
        #1;
        check("rd", bus.RD, exp_rd);
        check("gpio_out", {24'h0, gpio_out}, m_out);
        check("gpio_oe", {24'h0, gpio_oe}, m_dir);
        check("irq", {31'h0, irq}, {31'h0, (IRQ_BUILD && (m_is & m_ie) != 0)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        gpio_in = '0; in1 = '0; in32 = '0;
        bus.WE = 1'b0;   bus.A = '0;   bus.WD = '0;
        bus1.WE = 1'b0;  bus1.A = '0;  bus1.WD = '0;
        bus32.WE = 1'b0; bus32.A = '0; bus32.WD = '0;
        model_reset();
        #12;
        check("reset_rd", bus.RD, 32'h0);
        check("reset_out", {24'h0, gpio_out}, 32'h0);
        check("reset_oe", {24'h0, gpio_oe}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        @(negedge CLK);
        reset = 1'b0;

        // SET/CLR aliases
        step(1'b1, B + 32'h00, 32'h0F);
        step(1'b1, B + 32'h0C, 32'hF0);
        step(1'b1, B + 32'h10, 32'h03);
        check("setclr_out", {24'h0, gpio_out}, 32'hFC);
        step(1'b0, B + 32'h00, 32'h0);
        check("setclr_read", bus.RD, 32'hFC);
        step(1'b0, B + 32'h0C, 32'h0);
        check("set_reads0", bus.RD, 32'h0);
        step(1'b0, B + 32'h10, 32'h0);
        check("clr_reads0", bus.RD, 32'h0);

        // Input path latency and unselected window
        gpio_in = 8'hA5;
        step(1'b0, B + 32'h20, 32'h0);
        check("unselected", bus.RD, 32'h0);
        idle(1);
        step(1'b0, B + 32'h08, 32'h0);
        check("in_read", bus.RD, 32'hA5);

`ifdef GPIO_BANK_IRQ_EN
        gpio_in = 8'h00;
        step(1'b1, B + 32'h1C, 32'h08);
        step(1'b1, B + 32'h14, 32'h08);
        idle(3);
        step(1'b1, B + 32'h18, 32'hFF);
        gpio_in = 8'h08;
        idle(2);
        check("irq_early", {31'h0, irq}, 32'h0);
        idle(1);
        check("irq_rise", {31'h0, irq}, 32'h1);
        step(1'b0, B + 32'h18, 32'h0);
        check("is_rise", bus.RD, 32'h08);
        step(1'b1, B + 32'h18, 32'h08);
        check("irq_w1c", {31'h0, irq}, 32'h0);
        gpio_in = 8'h00;
        idle(4);
        check("irq_fall", {31'h0, irq}, 32'h0);
        step(1'b0, B + 32'h18, 32'h0);
        check("is_fall", bus.RD, 32'h0);
        gpio_in = 8'h08;
        idle(3);
        gpio_in = 8'h00;
        idle(3);
        gpio_in = 8'h08;
        idle(2);
        step(1'b1, B + 32'h18, 32'h08);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        step(1'b0, B + 32'h18, 32'h0);
        check("is_set_wins", bus.RD, 32'h08);
`else
        step(1'b1, B + 32'h14, 32'hFF);
        step(1'b0, B + 32'h14, 32'h0);
        check("ie_absent", bus.RD, 32'h0);
`endif

        // Asynchronous reset mid-run
        step(1'b1, B + 32'h00, 32'hFF);
        step(1'b1, B + 32'h04, 32'hFF);
        step(1'b0, B + 32'h00, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rd", bus.RD, 32'h0);
        check("async_out", {24'h0, gpio_out}, 32'h0);
        check("async_oe", {24'h0, gpio_oe}, 32'h0);
        check("async_irq", {31'h0, irq}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        model_reset();

        // Width sweep across 8, 1 and 32 pin instances
        step(1'b1, B + 32'h00, 32'hFFFF_FFFF);
        step(1'b0, B + 32'h00, 32'h0);
        check("n1_out_read", bus1.RD, 32'h0000_0001);
        check("n32_out_read", bus32.RD, 32'hFFFF_FFFF);
        check("n8_out_read", bus.RD, 32'h0000_00FF);
`ifndef GPIO_BANK_IRQ_EN
        step(1'b1, B + 32'h14, 32'hFFFF_FFFF);
        step(1'b0, B + 32'h14, 32'h0);
        check("n32_ie_absent", bus32.RD, 32'h0);
        step(1'b0, B + 32'h18, 32'h0);
        check("n32_is_absent", bus32.RD, 32'h0);
        check("n32_irq", {31'h0, irq32}, 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic        we;
            if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ 8'($urandom);
            if ($urandom_range(0, 9) == 0)
                a = B + 32'h20 + 32'($urandom_range(0, 255));
            else
                a = B | {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            step(we, a, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
